// File: rtl/progmem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : progmem_loader
//  Purpose  : Writable 16x8 program store for the TD4 CPU with a byte-stream
//             load sequencer. The CPU fetches through a combinational read
//             port. A host streams 16 image bytes followed by an 8-bit
//             checksum over a valid/ready handshake. The CPU is held halted
//             while a load is in progress or after a failed load.
//  Ports    : CLK       - system clock, rising edge
//             RESET     - synchronous active-high reset
//             START     - load request (restarts any load in progress)
//             DIN       - load byte
//             DVALID    - DIN valid
//             DREADY    - loader accepts a byte this cycle
//             PC        - CPU fetch address
//             INST      - instruction at PC (combinational)
//             CPU_HALT  - hold CPU stalled
//             ERR       - last load failed its checksum
//             DONE      - one-cycle pulse on a successful load
//  Revision : 1.0 - initial release
// ============================================================================
module progmem_loader (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] DIN,
  input  logic       DVALID,
  output logic       DREADY,
  input  logic [3:0] PC,
  output logic [7:0] INST,
  output logic       CPU_HALT,
  output logic       ERR,
  output logic       DONE
);

  localparam logic [1:0] c_ST_RUN   = 2'd0;
  localparam logic [1:0] c_ST_LOAD  = 2'd1;
  localparam logic [1:0] c_ST_CHECK = 2'd2;
  localparam logic [1:0] c_ST_ERROR = 2'd3;

  // Power-on program: byte n lives at bits [8n+7:8n].
  localparam logic [127:0] c_RESET_IMAGE = {96'h0, 8'hF0, 8'h90, 8'h40, 8'h20};

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic [3:0] r_idx;
  logic [7:0] r_sum;
  logic       r_done;
  logic [7:0] r_mem [16];
  logic       w_xfer;

  // DREADY is a pure state decode, so a transfer is simply valid-and-ready.
  assign w_xfer = DVALID & DREADY;

  assign INST = r_mem[PC];
  assign DONE = r_done;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= c_ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; START overrides a same-cycle transfer in every state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_RUN: begin
        if (START) w_state_next = c_ST_LOAD;
      end
      c_ST_LOAD: begin
        if (START)                          w_state_next = c_ST_LOAD;
        else if (w_xfer && r_idx == 4'd15)  w_state_next = c_ST_CHECK;
      end
      c_ST_CHECK: begin
        if (START)       w_state_next = c_ST_LOAD;
        else if (w_xfer) w_state_next = (DIN == r_sum) ? c_ST_RUN : c_ST_ERROR;
      end
      c_ST_ERROR: begin
        if (START) w_state_next = c_ST_LOAD;
      end
      default: w_state_next = c_ST_RUN;
    endcase
  end

  // Output decode
  always_comb begin
    DREADY   = 1'b0;
    CPU_HALT = 1'b0;
    ERR      = 1'b0;
    case (r_state)
      c_ST_RUN: begin
        DREADY   = 1'b0;
        CPU_HALT = 1'b0;
      end
      c_ST_LOAD, c_ST_CHECK: begin
        DREADY   = 1'b1;
        CPU_HALT = 1'b1;
      end
      c_ST_ERROR: begin
        CPU_HALT = 1'b1;
        ERR      = 1'b1;
      end
      default: begin
        DREADY   = 1'b0;
        CPU_HALT = 1'b0;
      end
    endcase
  end

  // Datapath: write index, running checksum, memory and DONE pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_idx  <= 4'd0;
      r_sum  <= 8'd0;
      r_done <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_mem[i] <= c_RESET_IMAGE[i*8 +: 8];
      end
    end else begin
      r_done <= 1'b0;
      if (START) begin
        // A byte offered alongside START is dropped; memory keeps what it has.
        r_idx <= 4'd0;
        r_sum <= 8'd0;
      end else if (w_xfer && r_state == c_ST_LOAD) begin
        r_mem[r_idx] <= DIN;
        r_sum        <= r_sum + DIN;
        r_idx        <= r_idx + 4'd1;
      end else if (w_xfer && r_state == c_ST_CHECK && DIN == r_sum) begin
        r_done <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_progmem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_progmem_loader
//  Purpose  : Self-checking bench for progmem_loader. A queue-based model
//             collects accepted bytes and judges the checksum once 17 have
//             arrived; outputs and INST are compared every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_progmem_loader;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       DVALID = 1'b0;
  logic [3:0] PC = 4'd0;
  logic       DREADY, CPU_HALT, ERR, DONE;
  logic [7:0] INST;

  progmem_loader dut (
    .CLK(CLK), .RESET(RESET), .START(START), .DIN(DIN), .DVALID(DVALID),
    .DREADY(DREADY), .PC(PC), .INST(INST), .CPU_HALT(CPU_HALT),
    .ERR(ERR), .DONE(DONE)
  );

  always #50 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a load is a list of accepted bytes; the first 16 land in
  // memory, the 17th is compared with their sum modulo 256.
  logic [7:0] m_mem [16];
  bit         m_loading, m_err, m_done;
  logic [7:0] m_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mem = '{8'h20, 8'h40, 8'h90, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    m_loading = 0; m_err = 0; m_done = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    int sum;
    if (RESET) begin
      model_reset();
    end else begin
      m_done = 0;
      if (START) begin
        m_loading = 1; m_err = 0;
        m_q.delete();
      end else if (m_loading && DVALID) begin
        m_q.push_back(DIN);
        if (m_q.size() <= 16) begin
          m_mem[m_q.size()-1] = DIN;
        end else begin
          sum = 0;
          for (int i = 0; i < 16; i++) sum += int'(m_q[i]);
          m_loading = 0;
          if ((sum % 256) == int'(m_q[16])) m_done = 1;
          else                             m_err  = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("DREADY",   {31'd0, DREADY},   {31'd0, m_loading});
    check_eq("CPU_HALT", {31'd0, CPU_HALT}, {31'd0, m_loading | m_err});
    check_eq("ERR",      {31'd0, ERR},      {31'd0, m_err});
    check_eq("DONE",     {31'd0, DONE},     {31'd0, m_done});
    check_eq("INST",     {24'd0, INST},     {24'd0, m_mem[PC]});
  endtask

  // One clock: advance model with the inputs present at the edge, then check.
  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit st, input bit vld, input logic [7:0] d);
    START = st; DVALID = vld; DIN = d;
    PC = 4'($urandom_range(0, 15));
    cycle();
  endtask

  task automatic sweep_pc();
    for (int p = 0; p < 16; p++) begin
      PC = 4'(p);
      #1;
      check_eq($sformatf("INST_PC%0d", p), {24'd0, INST}, {24'd0, m_mem[p]});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'($urandom));
  endtask

  initial begin
    logic [7:0] img [16];
    int         s;
    model_reset();

    // Reset
    RESET = 1;
    cycle(); cycle();
    RESET = 0;
    sweep_pc();
    idle(2);

    // Good load: 0x01..0x10, checksum 0x88
    drive(1, 0, 8'h00);
    for (int i = 1; i <= 16; i++) drive(0, 1, 8'(i));
    drive(0, 1, 8'h88);
    check_eq("good_done", {31'd0, DONE}, 32'd1);
    idle(2);
    PC = 4'd5; #1;
    check_eq("good_pc5", {24'd0, INST}, 32'h06);
    sweep_pc();

    // Bad checksum, then ignored traffic, then START
    drive(1, 0, 8'h00);
    for (int i = 1; i <= 16; i++) drive(0, 1, 8'(i));
    drive(0, 1, 8'h87);
    check_eq("bad_err", {31'd0, ERR}, 32'd1);
    for (int i = 0; i < 5; i++) drive(0, 1, 8'hAA);
    sweep_pc();
    drive(1, 0, 8'h00);
    check_eq("bad_restart_ready", {31'd0, DREADY}, 32'd1);

    // Gapped handshake: 0xFF x16, checksum 0xF0
    drive(1, 0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 8'hFF);
      drive(0, 0, 8'h00);
    end
    drive(0, 1, 8'hF0);
    check_eq("gap_done", {31'd0, DONE}, 32'd1);
    idle(1);

    // Restart priority: 7 bytes, START with a valid 0x55, then 0x11 x16 / 0x10
    drive(1, 0, 8'h00);
    for (int i = 0; i < 7; i++) drive(0, 1, 8'($urandom));
    drive(1, 1, 8'h55);
    for (int i = 0; i < 16; i++) drive(0, 1, 8'h11);
    drive(0, 1, 8'h10);
    check_eq("restart_done", {31'd0, DONE}, 32'd1);
    idle(1);
    sweep_pc();

    // Reset mid-load
    drive(1, 0, 8'h00);
    for (int i = 0; i < 9; i++) drive(0, 1, 8'($urandom));
    RESET = 1;
    drive(0, 0, 8'h00);
    RESET = 0;
    check_eq("rst_halt", {31'd0, CPU_HALT}, 32'd0);
    sweep_pc();

    // Randomized loads: random gaps, occasional restarts and bad checksums
    for (int n = 0; n < 30; n++) begin
      drive(1, 0, 8'h00);
      s = 0;
      for (int i = 0; i < 16; i++) begin
        img[i] = 8'($urandom);
        s += int'(img[i]);
      end
      for (int i = 0; i < 16; i++) begin
        while ($urandom_range(0, 2) == 0) drive(0, 0, 8'($urandom));
        if ($urandom_range(0, 40) == 0) drive(1, $urandom_range(0, 1) == 1, 8'($urandom));
        drive(0, 1, img[i]);
      end
      if ($urandom_range(0, 3) == 0) drive(0, 1, 8'(s + 1 + int'($urandom_range(0, 254))));
      else                           drive(0, 1, 8'(s));
      idle($urandom_range(1, 4));
      if (n % 10 == 9) sweep_pc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
